// File: rtl/noc_output_port_switch.sv
// Router output-port switch: per-VC packet FSMs, round-robin flit mux onto the link,
// downstream credit tracking. Optional checker enabled by NOC_OUTPUT_PORT_CHECK_EN.
module noc_output_port_switch #(
  parameter  int CHANNELS     = 2,
  parameter  int FLIT_WIDTH   = 32,
  parameter  int CREDIT_DEPTH = 4,
  localparam int VW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst,
  input  logic [CHANNELS-1:0][4:0]   grant_i,
  output logic [CHANNELS-1:0]        free_o,
  output logic [CHANNELS-1:0]        vc_ready_o,
  input  logic [4:0]                 in_valid,
  input  logic [4:0][VW-1:0]         in_vc,
  input  logic [4:0][FLIT_WIDTH-1:0] in_data,
  input  logic [4:0]                 in_tail,
  output logic [4:0]                 in_ready,
  output logic                       out_valid,
  output logic [VW-1:0]              out_vc,
  output logic [FLIT_WIDTH-1:0]      out_data,
  output logic                       out_tail,
  input  logic [CHANNELS-1:0]        credit_return_i
`ifdef NOC_OUTPUT_PORT_CHECK_EN
  ,
  output logic                       credit_err_o
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [3:0] CREDIT_FULL = 4'(CREDIT_DEPTH);
  localparam logic [VW-1:0] LAST_VC  = VW'(CHANNELS - 1);

  logic [CHANNELS-1:0][1:0] state_q, state_d;
  logic [CHANNELS-1:0][3:0] credit_q, credit_d;
  logic [VW-1:0]            rr_ptr_q;

  logic [CHANNELS-1:0][2:0] src_idx;
  logic [CHANNELS-1:0]      eligible;
  logic                     win_valid;
  logic [VW-1:0]            win_vc;
  logic [2:0]               win_src;

  // Source port of each VC: lowest set bit of its grant, so a malformed
  // multi-hot grant still selects a single port.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    src_idx  = '0;
    eligible = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      for (int p = 4; p >= 0; p--) begin
        if (grant_i[v][p]) src_idx[v] = 3'(p);
      end
      eligible[v] = (state_q[v] == ST_ACTIVE) && (|grant_i[v]) &&
                    in_valid[src_idx[v]] && (in_vc[src_idx[v]] == VW'(v)) &&
                    (credit_q[v] != 4'd0);
    end
  end

  // Round-robin: first eligible VC at or after the pointer wins the link.
  always_comb begin
    int            off;
    logic [VW-1:0] cand;
    off       = 0;
    cand      = '0;
    win_valid = 1'b0;
    win_vc    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      off = int'(rr_ptr_q) + i;
      if (off >= CHANNELS) off = off - CHANNELS;
      cand = VW'(off);
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win_vc    = cand;
      end
    end
  end

  assign win_src  = src_idx[win_vc];
  assign in_ready = win_valid ? (5'b00001 << win_src) : 5'b00000;

  // Per-VC packet FSM and credit counter next-state.
  always_comb begin
    logic dec;
    logic inc;
    state_d  = state_q;
    credit_d = credit_q;
    dec      = 1'b0;
    inc      = 1'b0;
    for (int v = 0; v < CHANNELS; v++) begin
      dec = win_valid && (win_vc == VW'(v));
      inc = credit_return_i[v];
      case (state_q[v])
        ST_IDLE:    if (|grant_i[v]) state_d[v] = ST_ACTIVE;
        ST_ACTIVE:  if (dec && in_tail[src_idx[v]]) state_d[v] = ST_RELEASE;
        ST_RELEASE: state_d[v] = ST_IDLE;
        default:    state_d[v] = ST_IDLE;
      endcase
      // A transfer and a return in the same cycle cancel out.
      if (dec && !inc)
        credit_d[v] = credit_q[v] - 4'd1;
      else if (inc && !dec && (credit_q[v] != CREDIT_FULL))
        credit_d[v] = credit_q[v] + 4'd1;
    end
  end

  always_comb begin
    free_o     = '0;
    vc_ready_o = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      free_o[v]     = (state_q[v] == ST_RELEASE);
      vc_ready_o[v] = (credit_q[v] != 4'd0);
    end
  end

  always_ff @(posedge noc_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (noc_rst) begin
      state_q  <= '0;
      credit_q <= {CHANNELS{CREDIT_FULL}};
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      if (win_valid) rr_ptr_q <= (win_vc == LAST_VC) ? '0 : win_vc + VW'(1);
    end
  end

  // Link register: a flit accepted this cycle is presented on the link next cycle.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      out_valid <= 1'b0;
      out_vc    <= '0;
      out_data  <= '0;
      out_tail  <= 1'b0;
    end else begin
      out_valid <= win_valid;
      if (win_valid) begin
        out_vc   <= win_vc;
        out_data <= in_data[win_src];
        out_tail <= in_tail[win_src];
      end
    end
  end

`ifdef NOC_OUTPUT_PORT_CHECK_EN
  logic [CHANNELS-1:0][4:0] grant_q;
  logic                     err_set;
  logic                     err_q;

  always_comb begin
    err_set = 1'b0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (credit_return_i[v] && (credit_q[v] == CREDIT_FULL)) err_set = 1'b1;
      if (state_q[v] == ST_ACTIVE) begin
        if (grant_i[v] == 5'd0) err_set = 1'b1;
        if ((grant_i[v] & (grant_i[v] - 5'd1)) != 5'd0) err_set = 1'b1;
        if (grant_i[v] != grant_q[v]) err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_i;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign credit_err_o = err_q;
`endif

endmodule
